// File: rtl/ctrl_seq.sv
// Multi-phase control sequencer for data_path: FETCH/DECODE/EXEC/(MEM)/WB with
// run/step/halt debug control and a retired-instruction counter.
module ctrl_seq #(
  parameter int unsigned CNT_W   = 32,
  parameter logic [5:0]  HALT_OP = 6'h3F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      imData,
  input  logic             aluZero,
  input  logic             run,
  input  logic             step,
  output logic [5:0]       op,
  output logic [1:0]       d1,
  output logic             d2,
  output logic             d3,
  output logic             d4,
  output logic             regWr,
  output logic             regMem,
  output logic             we,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OPC_R    = 6'h00;
  localparam logic [5:0] OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_LW   = 6'h23;
  localparam logic [5:0] OPC_SW   = 6'h2B;
  localparam logic [5:0] OPC_BEQ  = 6'h04;
  localparam logic [5:0] OPC_J    = 6'h02;
  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_SUB  = 6'h22;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  typedef struct packed {
    logic [5:0] op;
    logic       d2;
    logic       d3;
    logic       d4;
    logic       mem;
    logic       store;
    logic       wr;
    logic       beq;
    logic       jmp;
    logic       legal;
    logic       halt;
  } dec_t;

  state_t     state;
  logic [5:0] ir_op;
  logic [5:0] ir_fn;
  logic [5:0] dec_op;
  logic [5:0] dec_fn;
  dec_t       dec;

  logic unused_imdata;
  assign unused_imdata = ^imData[25:6];

  function automatic dec_t decode(input logic [5:0] opc, input logic [5:0] fn);
    dec_t d;
    d = '0;
    if (opc == HALT_OP) begin
      d.halt = 1'b1;
    end else begin
      case (opc)
        OPC_R:    begin d.op = fn;      d.d3 = 1'b1; d.wr = 1'b1; d.legal = 1'b1; end
        OPC_ADDI: begin d.op = ALU_ADD; d.d2 = 1'b1; d.wr = 1'b1; d.legal = 1'b1; end
        OPC_LW:   begin
          d.op = ALU_ADD; d.d2 = 1'b1; d.d4 = 1'b1;
          d.mem = 1'b1;   d.wr = 1'b1; d.legal = 1'b1;
        end
        OPC_SW:   begin d.op = ALU_ADD; d.mem = 1'b1; d.store = 1'b1; d.legal = 1'b1; end
        OPC_BEQ:  begin d.op = ALU_SUB; d.d3 = 1'b1; d.beq = 1'b1; d.legal = 1'b1; end
        OPC_J:    begin d.jmp = 1'b1; d.legal = 1'b1; end
        default:  d = '0;
      endcase
    end
    return d;
  endfunction

  // In FETCH the IR is being loaded this edge, so decode straight from imData
  // to have the registered outputs valid on entry to DECODE.
  always_comb begin
    dec_op = ir_op;
    dec_fn = ir_fn;
    if (state == S_FETCH) begin
      dec_op = imData[31:26];
      dec_fn = imData[5:0];
    end
    dec = decode(dec_op, dec_fn);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ir_op     <= '0;
      ir_fn     <= '0;
      op        <= '0;
      d1        <= '0;
      d2        <= 1'b0;
      d3        <= 1'b0;
      d4        <= 1'b0;
      regWr     <= 1'b0;
      regMem    <= 1'b0;
      we        <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
      instr_cnt <= '0;
    end else begin
      regWr  <= 1'b0;
      regMem <= 1'b0;
      we     <= 1'b0;
      d1     <= '0;
      case (state)
        S_IDLE: begin
          if (run || step) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          ir_op <= imData[31:26];
          ir_fn <= imData[5:0];
          op    <= dec.op;
          d2    <= dec.d2;
          d3    <= dec.d3;
          d4    <= dec.d4;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (dec.legal) begin
            state <= S_EXEC;
          end else begin
            state  <= S_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
            err    <= ~dec.halt;
            op     <= '0;
            d2     <= 1'b0;
            d3     <= 1'b0;
            d4     <= 1'b0;
          end
        end
        S_EXEC: begin
          if (dec.mem) begin
            state  <= S_MEM;
            regMem <= dec.store;
          end else begin
            // Branch outcome is taken from aluZero at this edge and held through WB.
            state <= S_WB;
            we    <= 1'b1;
            regWr <= dec.wr;
            if (dec.jmp)
              d1 <= 2'b11;
            else if (dec.beq && aluZero)
              d1 <= 2'b01;
          end
        end
        S_MEM: begin
          state <= S_WB;
          we    <= 1'b1;
          regWr <= dec.wr;
        end
        S_WB: begin
          instr_cnt <= instr_cnt + CNT_W'(1);
          op        <= '0;
          d2        <= 1'b0;
          d3        <= 1'b0;
          d4        <= 1'b0;
          if (run) begin
            state <= S_FETCH;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_HALTED: state <= S_HALTED;
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
